path_replayer: RTL

Downstream consumer of the solved-path move stream. After the solver has buffered its path, this block pops moves one at a time from the move queue, re-applies each to a coordinate pair starting at (0,0), and holds each position for a programmable dwell so the path can be shown or checked step by step. It reports the step count, arrival at the goal corner, and illegal (out-of-grid) moves.

---
 rtl/maze_pkg.sv | 38 +++
 rtl/replay_step_unit.sv | 58 +++++
 rtl/path_replayer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : maze_pkg
//  Purpose  : Shared types and constants for the maze path replay slice:
//             move encoding, default coordinate width, goal corner and the
//             replay FSM state encoding.
//  Options  : REPLAY_BOUNDS_CHECK_EN (consumed by replay_step_unit)
//  Revision : 1.0  initial release
// ============================================================================
package maze_pkg;

  // Default grid coordinate width; the grid is 2^c_COORD_W cells square.
  localparam int c_COORD_W = 4;

  // Goal corner for the default grid (all-ones in both axes).
  localparam logic [c_COORD_W-1:0] c_GOAL_X = {c_COORD_W{1'b1}};
  localparam logic [c_COORD_W-1:0] c_GOAL_Y = {c_COORD_W{1'b1}};

  // Move encoding: bitwise complement of a move is its opposite move.
  typedef enum logic [1:0] {
    MV_XP = 2'b00,
    MV_YP = 2'b01,
    MV_YN = 2'b10,
    MV_XN = 2'b11
  } move_t;

  // Replay FSM state encoding.
  typedef logic [2:0] replay_state_t;

  localparam replay_state_t c_ST_IDLE   = 3'd0;
  localparam replay_state_t c_ST_FETCH  = 3'd1;
  localparam replay_state_t c_ST_STEP   = 3'd2;
  localparam replay_state_t c_ST_DWELL  = 3'd3;
  localparam replay_state_t c_ST_FINISH = 3'd4;
  localparam replay_state_t c_ST_ERROR  = 3'd5;

endpackage : maze_pkg
`default_nettype wire

// File: rtl/replay_step_unit.sv
`default_nettype none
// ============================================================================
//  Module   : replay_step_unit
//  Purpose  : Combinational next-position calculator for one replayed move.
//             Produces the neighbouring coordinate (wrapping modulo grid
//             size) and an illegal flag for moves that leave the grid.
//  Options  : REPLAY_BOUNDS_CHECK_EN - when defined, moves crossing a grid
//             edge are flagged illegal; otherwise illegal is tied low and
//             coordinates simply wrap.
//  Revision : 1.0  initial release
// ============================================================================
module replay_step_unit
  import maze_pkg::*;
#(
  parameter int COORD_W = c_COORD_W
) (
  input  logic [COORD_W-1:0] i_pos_x,
  input  logic [COORD_W-1:0] i_pos_y,
  input  move_t              i_move,
  output logic [COORD_W-1:0] o_next_x,
  output logic [COORD_W-1:0] o_next_y,
  output logic               o_illegal
);

  localparam logic [COORD_W-1:0] c_ONE = {{(COORD_W-1){1'b0}}, 1'b1};

  // Neighbouring coordinate; arithmetic wraps naturally at the grid edge.
  always_comb begin
    o_next_x = i_pos_x;
    o_next_y = i_pos_y;
    case (i_move)
      MV_XP:   o_next_x = i_pos_x + c_ONE;
      MV_YP:   o_next_y = i_pos_y + c_ONE;
      MV_YN:   o_next_y = i_pos_y - c_ONE;
      default: o_next_x = i_pos_x - c_ONE;
    endcase
  end

`ifdef REPLAY_BOUNDS_CHECK_EN
  localparam logic [COORD_W-1:0] c_MAX  = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] c_ZERO = {COORD_W{1'b0}};

  // A move is illegal when it would step across the edge it is already on.
  always_comb begin
    o_illegal = 1'b0;
    case (i_move)
      MV_XP:   o_illegal = (i_pos_x == c_MAX);
      MV_YP:   o_illegal = (i_pos_y == c_MAX);
      MV_YN:   o_illegal = (i_pos_y == c_ZERO);
      default: o_illegal = (i_pos_x == c_ZERO);
    endcase
  end
`else
  assign o_illegal = 1'b0;
`endif

endmodule : replay_step_unit
`default_nettype wire

// File: rtl/path_replayer.sv
`default_nettype none
// ============================================================================
//  Module   : path_replayer
//  Purpose  : Pops solved-path moves from a show-ahead queue, re-applies them
//             to a coordinate pair starting at (0,0), holds each position for
//             a programmable dwell, and reports step count, goal arrival and
//             illegal moves.
//  Options  : REPLAY_BOUNDS_CHECK_EN - enable out-of-grid detection (ERROR
//             path). Without it coordinates wrap and err stays low.
//  Revision : 1.0  initial release
// ============================================================================
module path_replayer
  import maze_pkg::*;
#(
  parameter int COORD_W = c_COORD_W,
  parameter int DWELL_W = 8,
  parameter int STEP_W  = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               move_valid,
  input  logic [1:0]         move_in,
  output logic               move_rd,
  input  logic [DWELL_W-1:0] dwell,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [STEP_W-1:0]  step_cnt,
  output logic               busy,
  output logic               done,
  output logic               arrived,
  output logic               err
);

  localparam logic [COORD_W-1:0] c_GOAL      = {COORD_W{1'b1}};
  localparam logic [STEP_W-1:0]  c_STEP_MAX  = {STEP_W{1'b1}};
  localparam logic [STEP_W-1:0]  c_STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] c_DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] c_DWELL_0   = {DWELL_W{1'b0}};

  replay_state_t       r_state;
  move_t               r_move;
  logic [COORD_W-1:0]  r_pos_x;
  logic [COORD_W-1:0]  r_pos_y;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [DWELL_W-1:0]  r_dwell_cnt;
  logic                r_arrived;
  logic                r_err;

  logic [COORD_W-1:0]  w_next_x;
  logic [COORD_W-1:0]  w_next_y;
  logic                w_illegal;
  logic                w_at_goal;

  replay_step_unit #(
    .COORD_W (COORD_W)
  ) u_step (
    .i_pos_x   (r_pos_x),
    .i_pos_y   (r_pos_y),
    .i_move    (r_move),
    .o_next_x  (w_next_x),
    .o_next_y  (w_next_y),
    .o_illegal (w_illegal)
  );

  assign w_at_goal = (r_pos_x == c_GOAL) && (r_pos_y == c_GOAL);

  // Replay sequencing and the position / step / status registers it owns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_ST_IDLE;
      r_move      <= MV_XP;
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_step_cnt  <= '0;
      r_dwell_cnt <= '0;
      r_arrived   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_pos_x    <= '0;
            r_pos_y    <= '0;
            r_step_cnt <= '0;
            r_arrived  <= 1'b0;
            r_err      <= 1'b0;
            r_state    <= c_ST_FETCH;
          end
        end
        c_ST_FETCH: begin
          // An empty queue here means the path has been fully replayed.
          if (move_valid) begin
            r_move  <= move_t'(move_in);
            r_state <= c_ST_STEP;
          end else begin
            r_state <= c_ST_FINISH;
          end
        end
        c_ST_STEP: begin
          if (w_illegal) begin
            r_state <= c_ST_ERROR;
          end else begin
            r_pos_x     <= w_next_x;
            r_pos_y     <= w_next_y;
            if (r_step_cnt != c_STEP_MAX) begin
              r_step_cnt <= r_step_cnt + c_STEP_ONE;
            end
            r_dwell_cnt <= dwell;
            r_state     <= (dwell == c_DWELL_0) ? c_ST_FETCH : c_ST_DWELL;
          end
        end
        c_ST_DWELL: begin
          r_dwell_cnt <= r_dwell_cnt - c_DWELL_ONE;
          if (r_dwell_cnt == c_DWELL_ONE) begin
            r_state <= c_ST_FETCH;
          end
        end
        c_ST_FINISH: begin
          r_arrived <= w_at_goal;
          r_state   <= c_ST_IDLE;
        end
        c_ST_ERROR: begin
          r_err   <= 1'b1;
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // The dequeue strobe is combinational so the queue pops in the FETCH cycle.
  assign move_rd  = (r_state == c_ST_FETCH) && move_valid;
  assign busy     = (r_state != c_ST_IDLE);
  assign done     = (r_state == c_ST_FINISH) || (r_state == c_ST_ERROR);
  assign pos_x    = r_pos_x;
  assign pos_y    = r_pos_y;
  assign step_cnt = r_step_cnt;
  assign arrived  = r_arrived;
  assign err      = r_err;

endmodule : path_replayer
`default_nettype wire
